// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS sequencer driving datapath selects and strobes,
// with memory-ready wait states, a debug halt at instruction boundaries and a retire counter.
module mips_multicycle_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          OP,
    input  logic [5:0]          func,
    input  logic                mem_ready,
    input  logic                halt_req,
    output logic                PCWrite,
    output logic                PCWriteCondEQ,
    output logic                PCWriteCondNE,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                JalLink,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                halted,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB,
        BRANCH, JUMP, EXEC_I, IWB, JR, HALT
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] FN_JR = 6'b001000;

    state_t cur, nxt;

    assign state  = cur;
    assign halted = (cur == HALT);

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = halt_req ? HALT : (mem_ready ? DECODE : FETCH);
            DECODE:  nxt = (OP == OP_LW || OP == OP_SW) ? MEMADDR :
                           (OP == OP_R) ? ((func == FN_JR) ? JR : EXEC_R) :
                           (OP == OP_BEQ || OP == OP_BNE) ? BRANCH :
                           (OP == OP_J || OP == OP_JAL) ? JUMP :
                           (OP == OP_ADDI || OP == OP_ANDI || OP == OP_ORI || OP == OP_LUI) ? EXEC_I : FETCH;
            MEMADDR: nxt = (OP == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            EXEC_R:  nxt = RWB;
            EXEC_I:  nxt = IWB;
            HALT:    nxt = halt_req ? HALT : FETCH;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        PCWrite = 1'b0; PCWriteCondEQ = 1'b0; PCWriteCondNE = 1'b0; IorD = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0;
        RegDst = 1'b0; RegWrite = 1'b0; JalLink = 1'b0; ALUSrcA = 1'b0;
        ALUSrcB = 2'b00; ALUOp = 3'b000; PCSource = 2'b00;
        case (cur)
            FETCH: if (!halt_req) begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
            MEMWB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
            EXEC_R:  begin ALUSrcA = 1'b1; ALUOp = 3'b111; end
            RWB:     begin RegWrite = 1'b1; RegDst = 1'b1; end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (OP == OP_LUI) ? 3'b011 : (OP == OP_ORI) ? 3'b101 :
                          (OP == OP_ANDI) ? 3'b110 : 3'b100;
            end
            IWB:     RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 3'b001;
                PCSource      = 2'b01;
                PCWriteCondEQ = (OP == OP_BEQ);
                PCWriteCondNE = (OP == OP_BNE);
            end
            // jal links the PC that FETCH already advanced by 4
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = (OP == OP_JAL);
                JalLink  = (OP == OP_JAL);
            end
            JR:      begin PCWrite = 1'b1; PCSource = 2'b11; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= FETCH;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (nxt == FETCH && cur != FETCH && cur != HALT)
                instr_count <= instr_count + RETIRE_W'(1);
        end
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed instruction sequences checked every cycle against a
// per-instruction state-trace model plus literal pins of traces, counts and key strobes.
module tb_mips_multicycle_control;
    logic clk = 1'b0, reset = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
    logic [5:0] OP = '0, func = '0;
    logic PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegDst, RegWrite, JalLink, ALUSrcA, halted;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic [31:0] instr_count;

    mips_multicycle_control #(.RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .OP(OP), .func(func), .mem_ready(mem_ready), .halt_req(halt_req),
        .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .JalLink(JalLink), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .halted(halted), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic chk_on = 1'b0;
    int exp_state = 0;
    logic [31:0] exp_cnt = '0;
    logic [63:0] seen = '0;
    logic [3:0] br_snap = '0;
    logic [4:0] j_snap = '0;
    logic [1:0] jr_snap = '0;

    wire [19:0] dut_vec = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
                           MemtoReg, RegDst, RegWrite, JalLink, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted};

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Expected control word for a given phase, straight from the per-phase strobe table
    function automatic logic [19:0] exp_out(input int s, input logic [5:0] op, input logic mr, input logic hr);
        logic pcw = 0, eq = 0, ne = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, jl = 0, sa = 0, hl = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [2:0] ao = 0;
        case (s)
            0: if (!hr) begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            1: sb = 2'b11;
            2: begin sa = 1; sb = 2'b10; end
            3: begin mrd = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mwr = 1; iord = 1; end
            6: begin sa = 1; ao = 3'b111; end
            7: begin rw = 1; rd = 1; end
            8: begin sa = 1; ao = 3'b001; ps = 2'b01; eq = (op == 6'b000100); ne = (op == 6'b000101); end
            9: begin pcw = 1; ps = 2'b10; rw = (op == 6'b000011); jl = (op == 6'b000011); end
            10: begin
                sa = 1; sb = 2'b10;
                ao = (op == 6'b001000) ? 3'b100 : (op == 6'b001100) ? 3'b110 : (op == 6'b001101) ? 3'b101 : 3'b011;
            end
            11: rw = 1;
            12: begin pcw = 1; ps = 2'b11; end
            13: hl = 1;
            default: ;
        endcase
        return {pcw, eq, ne, iord, mrd, mwr, irw, m2r, rd, rw, jl, sa, sb, ao, ps, hl};
    endfunction

    always @(negedge clk) if (chk_on) begin
        chk("state", 64'(state), 64'(exp_state));
        chk("instr_count", 64'(instr_count), 64'(exp_cnt));
        chk("controls", 64'(dut_vec), 64'(exp_out(exp_state, OP, mem_ready, halt_req)));
        seen = {seen[59:0], state};
        if (state == 4'd8) br_snap = {PCWriteCondEQ, PCWriteCondNE, PCSource};
        if (state == 4'd9) j_snap = {PCWrite, PCSource, RegWrite, JalLink};
        if (state == 4'd12) jr_snap = PCSource;
    end

    // Builds the phase trace of one instruction from its class, then plays it cycle by cycle
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input int halt_at);
        int q[$];
        repeat (fw + 1) q.push_back(0);
        q.push_back(1);
        if (op == 6'b100011) begin q.push_back(2); repeat (mw + 1) q.push_back(3); q.push_back(4); end
        else if (op == 6'b101011) begin q.push_back(2); repeat (mw + 1) q.push_back(5); end
        else if (op == 6'b000000) begin
            if (fn == 6'b001000) q.push_back(12); else begin q.push_back(6); q.push_back(7); end
        end
        else if (op == 6'b000100 || op == 6'b000101) q.push_back(8);
        else if (op == 6'b000010 || op == 6'b000011) q.push_back(9);
        else if (op inside {6'b001000, 6'b001100, 6'b001101, 6'b001111}) begin q.push_back(10); q.push_back(11); end
        OP = op;
        func = fn;
        seen = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] inside {0, 3, 5}) mem_ready = (i + 1 >= q.size()) || (q[i + 1] != q[i]);
            else mem_ready = 1'($urandom_range(0, 1));
            if (i == halt_at) halt_req = 1'b1;
            exp_state = q[i];
            chk_on = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        exp_cnt++;
    endtask

    task automatic do_halt(input int n);
        exp_state = 0;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk); @(posedge clk); #1;
        exp_state = 13;
        repeat (n) begin
            @(negedge clk);
            chk("halt_halted", 64'(halted), 64'd1);
            chk("halt_memread", 64'(MemRead), 64'd0);
            @(posedge clk); #1;
        end
        halt_req = 1'b0;
        @(negedge clk); @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(instr_count), 64'd0);
        chk("reset_memread", 64'(MemRead), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        do_instr(6'b000000, 6'b100000, 0, 0, -1);
        chk("rtype_trace", seen, 64'h0167);
        chk("rtype_count", 64'(instr_count), 64'd1);

        do_instr(6'b100011, 6'd0, 0, 2, -1);
        chk("lw_trace", seen, 64'h0123334);
        chk("lw_count", 64'(instr_count), 64'd2);

        do_instr(6'b000100, 6'd0, 0, 0, -1);
        chk("beq_snap", 64'(br_snap), 64'b1001);
        do_instr(6'b000101, 6'd0, 0, 0, -1);
        chk("bne_snap", 64'(br_snap), 64'b0101);
        chk("branch_trace", seen, 64'h018);

        do_instr(6'b000011, 6'd0, 0, 0, -1);
        chk("jal_snap", 64'(j_snap), 64'b11011);
        do_instr(6'b000000, 6'b001000, 0, 0, -1);
        chk("jr_trace", seen, 64'h01C);
        chk("jr_pcsource", 64'(jr_snap), 64'b11);

        do_instr(6'b101011, 6'd0, 1, 1, -1);
        chk("sw_trace", seen, 64'h001255);
        do_instr(6'b001101, 6'd0, 0, 0, -1);
        do_instr(6'b001100, 6'd0, 2, 0, -1);
        do_instr(6'b001111, 6'd0, 0, 0, -1);
        do_instr(6'b000010, 6'd0, 0, 0, -1);
        chk("j_snap", 64'(j_snap), 64'b11000);
        chk("mix_count", 64'(instr_count), 64'd11);

        do_instr(6'b001000, 6'd0, 0, 0, 2);
        do_halt(3);
        chk("halt_count", 64'(instr_count), 64'd12);

        do_instr(6'b111111, 6'd0, 0, 0, -1);
        chk("nop_trace", seen, 64'h01);
        chk("nop_count", 64'(instr_count), 64'd13);

        chk_on = 1'b0;
        OP = 6'b100011;
        func = 6'd0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_abort_state", 64'(state), 64'd2);
        reset = 1'b0;
        #1;
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_count", 64'(instr_count), 64'd0);
        exp_cnt = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        do_instr(6'b000000, 6'b100010, 0, 0, -1);
        chk("post_abort_count", 64'(instr_count), 64'd1);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multicycle sequencer for the MIPS datapath. It replaces the single-cycle Control decode with an FSM that time-shares one ALU and one unified instruction/data memory across FETCH, DECODE, EXECUTE, MEM and WRITEBACK cycles. It drives all datapath mux selects and write enables, handles a memory ready handshake, provides a debug halt, and counts retired instructions.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
OP  input  6  opcode from the instruction register, bits [31:26].
func  input  6  function field, bits [5:0].
mem_ready  input  1  memory access completes this cycle.
halt_req  input  1  debug request to stop at the next instruction boundary.
PCWrite  output  1  unconditional PC load.
PCWriteCondEQ  output  1  PC load if ALU Zero=1.
PCWriteCondNE  output  1  PC load if ALU Zero=0.
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  output  1  memory read strobe.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  instruction register load.
MemtoReg  output  1  write-back source: 1 = MDR, 0 = ALUOut.
RegDst  output  1  destination register: 1 = rd, 0 = rt.
RegWrite  output  1  register file write.
JalLink  output  1  forces write register 31 and write data = PC.
ALUSrcA  output  1  ALU A input: 0 = PC, 1 = register A.
ALUSrcB  output  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
ALUOp  output  3  000 add, 001 sub, 011 lui, 100 addi, 101 ori, 110 andi, 111 R-type (use func).
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
halted  output  1  FSM is in HALT.
state  output  4  current state code, for debug.
instr_count  output  RETIRE_W  count of retired instructions.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH(0), instr_count=0. All outputs take their FETCH decode values.
- State codes: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, RWB 7, BRANCH 8, JUMP 9, EXEC_I 10, IWB 11, JR 12, HALT 13. Codes 14 and 15 are illegal and go to FETCH on the next clock.
- Outputs are decoded from the state. Only the mem_ready gating listed below is Mealy. Any strobe not listed for a state is 0.
- FETCH:
  - halt_req=1: all strobes 0; next state HALT.
  - Otherwise: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (computes the branch target). Next state by opcode:
  - lw 100011, sw 101011 → MEMADDR.
  - OP=000000 with func=001000 (jr) → JR; other OP=000000 → EXEC_R.
  - beq 000100, bne 000101 → BRANCH.
  - j 000010, jal 000011 → JUMP.
  - addi 001000, andi 001100, ori 001101, lui 001111 → EXEC_I.
  - Any other opcode is retired as a NOP → FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode. Next state IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. Asserts PCWriteCondEQ (beq) or PCWriteCondNE (bne). Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. For jal only, also RegWrite=1 and JalLink=1; the link value is the PC already incremented in FETCH. Next state FETCH.
- JR: PCWrite=1, PCSource=11. Next state FETCH.
- HALT: halted=1, all strobes 0. Leaves to FETCH when halt_req=0.
- halt_req is sampled only in FETCH. An instruction already in progress always completes.
- Retirement: instr_count increments by 1 on every clock edge whose next state is FETCH from a state other than FETCH or HALT. This includes NOP retire from DECODE.
  - Wraps from all-ones to 0.
  - Does not change during wait cycles or in HALT.
- Latency with mem_ready tied to 1:
  - beq, bne, j, jal, jr: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction aborts immediately to FETCH with instr_count=0. No strobe glitches high during reset.

Test Plan:
- Reset, then OP=000000, func=100000, mem_ready=1 → states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7; instr_count=1.
- lw (OP=100011) with mem_ready=0 for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 through all MEMRD cycles; instr_count=1 after 8 cycles.
- beq (OP=000100) then bne (OP=000101) → state 8 reached in the 3rd cycle of each; PCWriteCondEQ=1 and PCWriteCondNE=1 respectively; PCSource=01 both times; instr_count=2.
- jal (OP=000011) → JUMP cycle shows PCWrite=1, PCSource=10, RegWrite=1, JalLink=1; jr (OP=0, func=001000) → state 12 with PCSource=11.
- halt_req=1 raised during EXEC_I of addi → addi completes (IWB, then FETCH); next cycle is HALT with halted=1 and MemRead=0; drop halt_req → FETCH; instr_count unchanged while halted.
- Illegal OP=111111 → states 0,1,0, counted as retired. Then assert reset=0 during MEMADDR → state=0 and instr_count=0 immediately, without waiting for a clock edge.
